// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit digit per cycle through an external 4-bit ripple
// adder, with the running carry and partial result held in local registers.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   cin,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_sum,
   input  logic                   add_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout
);

   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [W-1:0]      r_opA;
   logic [W-1:0]      r_opB;
   logic [W-1:0]      r_result;
   logic              r_carry;
   logic              r_cout;
   logic              r_outValid;
   logic [IDXW-1:0]   r_idx;
   logic              w_accept;
   logic              w_release;
   logic              w_lastDigit;

   assign w_accept    = (r_state == IDLE) && in_valid;
   assign w_release   = (r_state == DONE) && r_outValid && out_ready;
   assign w_lastDigit = (r_idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)    w_nextState = RUN;
         RUN:     if (w_lastDigit) w_nextState = DONE;
         DONE:    if (w_release)   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // out_valid is registered, so it rises one edge after DONE is entered;
   // this gives the fixed NIBBLES+1 latency from the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opA      <= '0;
         r_opB      <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_cout     <= 1'b0;
         r_idx      <= '0;
         r_outValid <= 1'b0;
      end else begin
         r_outValid <= (r_state == DONE) && !w_release;
         if (w_accept) begin
            r_opA    <= op_a;
            r_opB    <= op_b;
            r_carry  <= cin;
            r_cout   <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
         end else if (r_state == RUN) begin
            r_result[4*r_idx +: 4] <= add_sum;
            r_carry                <= add_cout;
            if (w_lastDigit) begin
               r_cout <= add_cout;
            end else begin
               r_idx <= r_idx + IDXW'(1);
            end
         end
      end
   end

   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (r_state == RUN) begin
         add_a   = r_opA[4*r_idx +: 4];
         add_b   = r_opB[4*r_idx +: 4];
         add_cin = r_carry;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_outValid;
   assign result    = r_result;
   assign cout      = r_cout;

endmodule
